// File: rtl/pixel_cdc_tx_if.sv
// Pixel stream in and req/ack toggle link out of pixel_cdc_tx.
// master is the transmitter's view; slave is the upstream source plus destination side.
interface pixel_cdc_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_r;
  logic [WIDTH-1:0] in_g;
  logic [WIDTH-1:0] in_b;
  logic             tx_req;
  logic [WIDTH-1:0] tx_r;
  logic [WIDTH-1:0] tx_g;
  logic [WIDTH-1:0] tx_b;
  logic             ack_async;

  modport master (
    input  in_valid, in_r, in_g, in_b, ack_async,
    output in_ready, tx_req, tx_r, tx_g, tx_b
  );

  modport slave (
    output in_valid, in_r, in_g, in_b, ack_async,
    input  in_ready, tx_req, tx_r, tx_g, tx_b
  );
endinterface

// File: rtl/pixel_cdc_tx.sv
// Pixel source-side CDC: 2-entry FIFO feeding a toggle req/ack launcher; push-to-tx 1 cycle, req edge 2 cycles.
// Backpressure: in_ready drops from registered occupancy when the FIFO holds 2; stalls until ack returns.
module pixel_cdc_tx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  pixel_cdc_tx_if.master      bus,
  input  logic                clr_err,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         sent_count
);

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [15:0] TMO    = 16'(TIMEOUT);
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  pix_t        fifo_q [2];
  pix_t        fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        rdy_en_q;
  logic        ack_s1_q, ack_s2_q;
  logic        tx_req_q, tx_req_d;
  pix_t        tx_pix_q, tx_pix_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [15:0] sent_q, sent_d;

  logic        in_ready;
  logic        push;
  logic        pop;
  logic        set_err;
  pix_t        pix_in;

  // rdy_en_q keeps in_ready low throughout reset and for the cycle it deasserts.
  assign in_ready = rdy_en_q && (count_q < 2'd2);
  assign push     = bus.in_valid && in_ready;
  assign pix_in   = '{r: bus.in_r, g: bus.in_g, b: bus.in_b};

  always_comb begin
    state_d  = state_q;
    tx_req_d = tx_req_q;
    tx_pix_d = tx_pix_q;
    timer_d  = timer_q;
    sent_d   = sent_q;
    pop      = 1'b0;
    set_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          tx_pix_d = fifo_q[rd_ptr_q];
          pop      = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_req_d = ~tx_req_q;
        timer_d  = 16'd0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s2_q == tx_req_q) begin
          sent_d  = sent_q + 16'd1;
          state_d = IDLE;
        end else begin
          if (timer_q != TMO) begin
            timer_d = timer_q + 16'd1;
          end
          // Fires only on the step into TIMEOUT, so a cleared flag stays clear while saturated.
          if (timer_q == TMO_M1) begin
            set_err = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (set_err) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = pix_in;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      rdy_en_q  <= 1'b0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_pix_q  <= '0;
      timer_q   <= 16'd0;
      err_q     <= 1'b0;
      sent_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdy_en_q  <= 1'b1;
      ack_s1_q  <= bus.ack_async;
      ack_s2_q  <= ack_s1_q;
      tx_req_q  <= tx_req_d;
      tx_pix_q  <= tx_pix_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      sent_q    <= sent_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.tx_req   = tx_req_q;
  assign bus.tx_r     = tx_pix_q.r;
  assign bus.tx_g     = tx_pix_q.g;
  assign bus.tx_b     = tx_pix_q.b;

  assign busy        = (state_q != IDLE) || (count_q != 2'd0);
  assign timeout_err = err_q;
  assign sent_count  = sent_q;

endmodule

// File: tb/tb_pixel_cdc_tx.sv
// Directed bench for pixel_cdc_tx with TIMEOUT=4: latency, backpressure, timeout, spurious ack, reset, wrap.
module tb_pixel_cdc_tx;

  logic        clk;
  logic        rst_n;
  logic        clr_err;
  logic        busy;
  logic        timeout_err;
  logic [15:0] sent_count;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_cdc_tx_if #(.WIDTH(8)) bus ();

  pixel_cdc_tx #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr_err     (clr_err),
    .busy        (busy),
    .timeout_err (timeout_err),
    .sent_count  (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_pix(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_r     = r;
    bus.in_g     = g;
    bus.in_b     = b;
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_err       = 1'b0;
    bus.ack_async = 1'b0;
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_tx_req", 32'(bus.tx_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);
    check("rst_tx_r", 32'(bus.tx_r), 32'd0);
    tick(2);
    check("rst_hold_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Single pixel latency and ack round trip
    drive_pix(1'b1, 8'h12, 8'h34, 8'h56);
    tick(1);
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);
    check("sp_n_tx_r", 32'(bus.tx_r), 32'd0);
    check("sp_n_busy", 32'(busy), 32'd1);
    tick(1);
    check("sp_n1_tx_r", 32'(bus.tx_r), 32'h12);
    check("sp_n1_tx_g", 32'(bus.tx_g), 32'h34);
    check("sp_n1_tx_b", 32'(bus.tx_b), 32'h56);
    check("sp_n1_req", 32'(bus.tx_req), 32'd0);
    tick(1);
    check("sp_n2_req", 32'(bus.tx_req), 32'd1);
    bus.ack_async = 1'b1;
    tick(2);
    check("sp_wait_sent", 32'(sent_count), 32'd0);
    check("sp_wait_busy", 32'(busy), 32'd1);
    tick(1);
    check("sp_done_sent", 32'(sent_count), 32'd1);
    check("sp_done_busy", 32'(busy), 32'd0);
    check("sp_done_err", 32'(timeout_err), 32'd0);

    // Spurious ack toggles while idle
    bus.ack_async = 1'b0;
    tick(4);
    check("spur_sent", 32'(sent_count), 32'd1);
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_req", 32'(bus.tx_req), 32'd1);
    bus.ack_async = 1'b1;
    tick(3);
    check("spur_back_sent", 32'(sent_count), 32'd1);

    // Backpressure with ack held, plus timeout and clear behaviour
    drive_pix(1'b1, 8'h01, 8'h02, 8'h03);
    tick(1);
    check("bp_rdy1", 32'(bus.in_ready), 32'd1);
    drive_pix(1'b1, 8'h11, 8'h12, 8'h13);
    tick(1);
    check("bp_tx_a", 32'(bus.tx_r), 32'h01);
    check("bp_rdy2", 32'(bus.in_ready), 32'd1);
    drive_pix(1'b1, 8'h21, 8'h22, 8'h23);
    tick(1);
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);
    check("bp_full", 32'(bus.in_ready), 32'd0);
    check("bp_req_a", 32'(bus.tx_req), 32'd0);
    tick(3);
    check("to_before", 32'(timeout_err), 32'd0);
    clr_err = 1'b1;
    tick(1);
    check("to_set_wins", 32'(timeout_err), 32'd1);
    check("to_tx_held", 32'(bus.tx_r), 32'h01);
    tick(1);
    check("to_cleared", 32'(timeout_err), 32'd0);
    clr_err = 1'b0;
    tick(1);
    check("to_stay_clear", 32'(timeout_err), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    check("to_still_full", 32'(bus.in_ready), 32'd0);
    bus.ack_async = 1'b0;
    tick(2);
    check("late_wait", 32'(sent_count), 32'd1);
    tick(1);
    check("late_done", 32'(sent_count), 32'd2);
    check("late_rdy_reg", 32'(bus.in_ready), 32'd0);
    tick(1);
    check("bp_tx_b", 32'(bus.tx_r), 32'h11);
    check("bp_rdy_b", 32'(bus.in_ready), 32'd1);
    tick(1);
    check("bp_req_b", 32'(bus.tx_req), 32'd1);
    bus.ack_async = 1'b1;
    tick(3);
    check("bp_sent_b", 32'(sent_count), 32'd3);
    tick(1);
    check("bp_tx_c", 32'(bus.tx_r), 32'h21);
    check("bp_tx_c_b", 32'(bus.tx_b), 32'h23);
    tick(1);
    check("bp_req_c", 32'(bus.tx_req), 32'd0);
    bus.ack_async = 1'b0;
    tick(3);
    check("bp_sent_c", 32'(sent_count), 32'd4);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset during WAIT_ACK with two pixels queued
    drive_pix(1'b1, 8'h31, 8'h32, 8'h33);
    tick(1);
    drive_pix(1'b1, 8'h41, 8'h42, 8'h43);
    tick(1);
    drive_pix(1'b1, 8'h51, 8'h52, 8'h53);
    tick(1);
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick(1);
    check("mr_full", 32'(bus.in_ready), 32'd0);
    check("mr_req", 32'(bus.tx_req), 32'd1);
    check("mr_tx", 32'(bus.tx_r), 32'h31);
    rst_n = 1'b0;
    #1;
    check("mr_req_rst", 32'(bus.tx_req), 32'd0);
    check("mr_tx_rst", 32'(bus.tx_r), 32'd0);
    check("mr_sent_rst", 32'(sent_count), 32'd0);
    check("mr_busy_rst", 32'(busy), 32'd0);
    check("mr_rdy_rst", 32'(bus.in_ready), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("mr_rdy_after", 32'(bus.in_ready), 32'd1);
    drive_pix(1'b1, 8'hA5, 8'h5A, 8'hC3);
    tick(1);
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);
    check("mr_push_tx", 32'(bus.tx_r), 32'd0);
    tick(1);
    check("mr_tx_r", 32'(bus.tx_r), 32'hA5);
    check("mr_tx_g", 32'(bus.tx_g), 32'h5A);
    check("mr_tx_b", 32'(bus.tx_b), 32'hC3);
    check("mr_req0", 32'(bus.tx_req), 32'd0);
    tick(1);
    check("mr_req1", 32'(bus.tx_req), 32'd1);
    bus.ack_async = 1'b1;
    tick(3);
    check("mr_sent", 32'(sent_count), 32'd1);

    // sent_count wrap
    force dut.sent_q = 16'hFFFF;
    tick(1);
    release dut.sent_q;
    check("wrap_pre", 32'(sent_count), 32'h0000FFFF);
    drive_pix(1'b1, 8'h77, 8'h88, 8'h99);
    tick(1);
    drive_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick(1);
    check("wrap_tx", 32'(bus.tx_r), 32'h77);
    tick(1);
    check("wrap_req", 32'(bus.tx_req), 32'd0);
    bus.ack_async = 1'b0;
    tick(2);
    check("wrap_hold", 32'(sent_count), 32'h0000FFFF);
    tick(1);
    check("wrap_zero", 32'(sent_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_cdc_tx.md
PIXEL_CDC_TX -- requirements
Module: pixel_cdc_tx

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each colour channel.
REQ-002 Parameter TIMEOUT, default 255: number of WAIT_ACK cycles before timeout_err is raised; legal range 2..65535.
REQ-003 Port clk  input  1  source-domain clock; all logic is clocked on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low; clock is clk.
REQ-005 Port in_valid  input  1  upstream pixel valid.
REQ-006 Port in_ready  output  1  block can accept a pixel (FIFO not full).
REQ-007 Port in_r / in_g / in_b  input  WIDTH each  upstream pixel channels.
REQ-008 Port tx_req  output  1  request toggle; each transition announces one new pixel to the destination domain.
REQ-009 Port tx_r / tx_g / tx_b  output  WIDTH each  launched pixel, held stable from load until ack.
REQ-010 Port ack_async  input  1  acknowledge toggle from the destination domain, asynchronous to clk.
REQ-011 Port clr_err  input  1  clears timeout_err.
REQ-012 Port busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-013 Port timeout_err  output  1  sticky flag: an ack has not arrived within TIMEOUT cycles.
REQ-014 Port sent_count  output  16  count of completed transfers.

Function
REQ-015 The block SHALL contain a 2-entry input FIFO of {r,g,b}; a push occurs when in_valid && in_ready.
REQ-016 in_ready SHALL be decoded from the registered FIFO occupancy as (count < 2); a pop in the same cycle SHALL NOT raise in_ready combinationally.
REQ-017 A push and a pop in the same cycle SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-018 ack_async SHALL pass through a 2-flop synchronizer (ack_s1, ack_s2); only ack_s2 is used by the logic.
REQ-019 The FSM SHALL have three states: IDLE, LAUNCH and WAIT_ACK.
REQ-020 IDLE with the FIFO non-empty: at the clock edge, load tx_r/g/b from the FIFO head, pop the FIFO, and go to LAUNCH. IDLE with the FIFO empty: remain in IDLE.
REQ-021 LAUNCH: toggle tx_req, clear the timeout timer, and go to WAIT_ACK. Data is therefore stable for at least one cycle before the req edge.
REQ-022 WAIT_ACK: when ack_s2 == tx_req, go to IDLE and increment sent_count; otherwise increment the timer, saturating at TIMEOUT.
REQ-023 tx_r/g/b SHALL change only on the IDLE->LAUNCH edge.
REQ-024 Latency: a pixel pushed at edge N into an empty FIFO with the FSM in IDLE SHALL appear on tx_* at edge N+1, with tx_req toggling at edge N+2.
REQ-025 Minimum period between successive tx_req toggles SHALL be 3 cycles plus the ack round-trip time.
REQ-026 timeout_err SHALL be set on the edge at which the timer reaches TIMEOUT while in WAIT_ACK. The FSM SHALL keep waiting; the transfer is not abandoned.
REQ-027 clr_err SHALL clear timeout_err; if set and clear occur in the same cycle, set wins.
REQ-028 sent_count SHALL wrap from 16'hFFFF to 0.
REQ-029 An ack_s2 transition outside WAIT_ACK SHALL be ignored and SHALL NOT change state or counters.

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE, FIFO empty, in_ready=0 during reset, tx_req=0, tx_r/g/b=0, ack_s1=ack_s2=0, timer=0, timeout_err=0, sent_count=0, busy=0.
REQ-031 Reset asserted mid-transfer SHALL discard the FIFO contents and the in-flight pixel; the destination domain SHALL be reset by the same event.
REQ-032 in_ready SHALL be 1 on the first clk edge after rst_n deasserts.

Verification
REQ-033 Single pixel: push (r,g,b)=(0x12,0x34,0x56) at edge N -> tx_*=(0x12,0x34,0x56) at N+1, tx_req 0->1 at N+2; drive ack_async=1 -> WAIT_ACK exits 3 cycles later, sent_count=1, busy=0.
REQ-034 Back-pressure: hold ack_async low and push 3 pixels back-to-back -> in_ready drops to 0 after 2 pushes in FIFO plus 1 launched; release acks -> all 3 pixels delivered in order, sent_count=3.
REQ-035 Timeout: TIMEOUT=4, no ack -> timeout_err=1 after 4 WAIT_ACK cycles with tx_* held; a late ack completes the transfer; clr_err -> timeout_err=0; clr_err asserted on the set cycle -> timeout_err=1.
REQ-036 Spurious ack: toggle ack_async while in IDLE -> no state change and sent_count unchanged.
REQ-037 Reset mid-WAIT_ACK with FIFO=2 -> all outputs return to their reset values; pushing after reset restarts with tx_req toggling 0->1.
REQ-038 Wrap: preload sent_count=16'hFFFF via 65535 transfers (or force) -> the next transfer yields sent_count=0.
